uart_rx: RTL and testbench

// - 8N1 UART receiver; the receive end of the team's UART_tx link (start bit, 8 data bits LSB first, 1 stop bit).
// - Synchronizes asynchronous RX, samples each bit at mid-period, assembles the byte and presents it with a rdy flag.
// - Flags framing and overrun errors; sits between the serial pin and the command/telemetry parser.

---
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial-side and consumer-side signals of the 8N1 receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frm_err,
        output ovr_err
    );

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frm_err,
        input  ovr_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling, framing/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int BAUD_DIV = 5209,
    parameter int HALF_DIV = 2604
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_rx_if.slave  bus
);

    localparam int              CNT_W         = 13;
    localparam logic [CNT_W-1:0] c_BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] c_HALF_RELOAD = CNT_W'(HALF_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_s_d;
    logic [2:0]       r_sync_vld;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rdy;
    logic             r_frm_err;
    logic             r_ovr_err;

    logic             w_tick;
    logic             w_fall;

    assign w_tick = (r_cnt == '0);
    // The preset-high sync stages are not real line history until they have
    // been refilled, so a line held low through reset never looks like a fall.
    assign w_fall = r_sync_vld[2] & r_rx_s_d & ~r_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_s_d   <= 1'b1;
            r_sync_vld <= 3'b000;
            r_cnt      <= '0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rdy      <= 1'b0;
            r_frm_err  <= 1'b0;
            r_ovr_err  <= 1'b0;
        end else begin
            r_rx_meta  <= bus.RX;
            r_rx_s     <= r_rx_meta;
            r_rx_s_d   <= r_rx_s;
            r_sync_vld <= {r_sync_vld[1:0], 1'b1};

            if (bus.clr_rdy) begin
                r_rdy     <= 1'b0;
                r_ovr_err <= 1'b0;
                r_frm_err <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_fall) begin
                        r_cnt     <= c_HALF_RELOAD;
                        r_bit_cnt <= 4'd0;
                        r_state   <= c_START;
                    end
                end
                c_START: begin
                    if (w_tick) begin
                        if (r_rx_s) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_cnt   <= c_BAUD_RELOAD;
                            r_state <= c_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_cnt     <= c_BAUD_RELOAD;
                        if (r_bit_cnt == 4'd7) begin
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_STOP: begin
                    if (w_tick) begin
                        r_state <= c_IDLE;
                        if (r_rx_s) begin
                            // Completion overrides a simultaneous acknowledge.
                            r_rx_data <= r_shift;
                            r_rdy     <= 1'b1;
                            r_frm_err <= 1'b0;
                            if (r_rdy && !bus.clr_rdy) begin
                                r_ovr_err <= 1'b1;
                            end
                        end else begin
                            r_frm_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.rx_data = r_rx_data;
    assign bus.rdy     = r_rdy;
    assign bus.frm_err = r_frm_err;
    assign bus.ovr_err = r_ovr_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard bench for uart_rx; frame-level model drives expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int BAUD = 16;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if u_if();

    uart_rx #(
        .BAUD_DIV (BAUD),
        .HALF_DIV (HALF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] exp_q[$];
    bit          mon_on  = 1'b0;

    // Frame-level view of what a consumer should see: {rx_data, rdy, frm_err, ovr_err}
    logic [7:0]  m_data;
    logic        m_rdy;
    logic        m_frm;
    logic        m_ovr;

    function automatic logic [10:0] observed();
        return {u_if.rx_data, u_if.rdy, u_if.frm_err, u_if.ovr_err};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_state(input logic [7:0] d, input logic r, input logic f, input logic o);
        if ({d, r, f, o} != {m_data, m_rdy, m_frm, m_ovr}) begin
            exp_q.push_back({d, r, f, o});
        end
        m_data = d;
        m_rdy  = r;
        m_frm  = f;
        m_ovr  = o;
    endtask

    task automatic clr_pulse();
        expect_state(m_data, 1'b0, 1'b0, 1'b0);
        u_if.clr_rdy = 1'b1;
        step(1);
        u_if.clr_rdy = 1'b0;
        step(3);
    endtask

    // rst_bit >= 0 pulses rst in the middle of that data bit; hold_clr keeps
    // clr_rdy high from the start of the stop bit until after it.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int rst_bit, input bit hold_clr);
        u_if.RX = 1'b0;
        step(BAUD);
        for (int i = 0; i < 8; i++) begin
            u_if.RX = b[i];
            if (i == rst_bit) begin
                step(BAUD / 2);
                expect_state(8'h00, 1'b0, 1'b0, 1'b0);
                rst = 1'b1;
                step(1);
                rst = 1'b0;
                step(BAUD - BAUD / 2 - 1);
            end else begin
                step(BAUD);
            end
        end
        if (rst_bit >= 0) begin
            u_if.RX = 1'b1;
            step(BAUD + 2);
        end else begin
            if (hold_clr) begin
                expect_state(m_data, 1'b0, 1'b0, 1'b0);
                expect_state(b, 1'b1, 1'b0, 1'b0);
                expect_state(b, 1'b0, 1'b0, 1'b0);
                u_if.clr_rdy = 1'b1;
            end else if (stop_ok) begin
                expect_state(b, 1'b1, 1'b0, m_rdy ? 1'b1 : m_ovr);
            end else begin
                expect_state(m_data, m_rdy, 1'b1, m_ovr);
            end
            u_if.RX = stop_ok;
            step(BAUD);
            u_if.RX = 1'b1;
            step(2);
            u_if.clr_rdy = 1'b0;
        end
    endtask

    // Monitor: every visible output change must match the next queued expectation.
    initial begin
        logic [10:0] prev;
        logic [10:0] cur;
        logic [10:0] e;
        wait (mon_on);
        prev = 11'h000;
        forever begin
            @(negedge clk);
            cur = observed();
            if (cur !== prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got %h, required unchanged %h", cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL frame_state: got data=%h rdy=%b frm=%b ovr=%b, required data=%h rdy=%b frm=%b ovr=%b",
                                 cur[10:3], cur[2], cur[1], cur[0], e[10:3], e[2], e[1], e[0]);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        m_data       = 8'h00;
        m_rdy        = 1'b0;
        m_frm        = 1'b0;
        m_ovr        = 1'b0;
        u_if.RX      = 1'b0;
        u_if.clr_rdy = 1'b0;
        rst          = 1'b1;
        step(3);
        rst    = 1'b0;
        mon_on = 1'b1;
        // Line held low across reset exit must not start a frame.
        step(40);
        u_if.RX = 1'b1;
        step(200);
        check("reset_rx_data", u_if.rx_data, 8'h00);
        check("reset_rdy", u_if.rdy, 1'b0);
        check("reset_frm_err", u_if.frm_err, 1'b0);
        check("reset_ovr_err", u_if.ovr_err, 1'b0);

        send_frame(8'hA5, 1'b1, -1, 1'b0);
        check("a5_data", u_if.rx_data, 8'hA5);
        clr_pulse();

        send_frame(8'h3C, 1'b1, -1, 1'b0);
        send_frame(8'hC3, 1'b1, -1, 1'b0);
        check("overrun_flag", u_if.ovr_err, 1'b1);
        clr_pulse();

        u_if.RX = 1'b0;
        step(4);
        u_if.RX = 1'b1;
        step(2 * BAUD);
        send_frame(8'h55, 1'b1, -1, 1'b0);
        clr_pulse();

        send_frame(8'hFF, 1'b0, -1, 1'b0);
        check("framing_keeps_data", u_if.rx_data, 8'h55);
        send_frame(8'h01, 1'b1, -1, 1'b0);

        send_frame(8'h81, 1'b1, 4, 1'b0);
        check("midframe_reset_rdy", u_if.rdy, 1'b0);
        send_frame(8'h7E, 1'b1, -1, 1'b0);
        check("after_reset_data", u_if.rx_data, 8'h7E);

        send_frame(8'h5A, 1'b1, -1, 1'b0);
        send_frame(8'h96, 1'b1, -1, 1'b1);
        step(5);

        for (int k = 0; k < 24; k++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok, -1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                clr_pulse();
            end
            step($urandom_range(0, 20));
        end

        step(50);
        check("pending_expectations", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
